// File: rtl/counter.sv
// Free-running modulo counter with programmable terminal value and combinational terminal-count flag.
// Optional synchronous clear port clr_i is enabled by defining COUNTER_CLR_EN.
module counter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef COUNTER_CLR_EN
  input  logic             clr_i,
`endif
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             overflow_o
);

  // Increment only happens below the limit, so the all-ones count never rolls over arithmetically.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input logic             at_limit);
    logic [WIDTH-1:0] nxt;
    nxt = cur + {{(WIDTH-1){1'b0}}, 1'b1};
    if (at_limit) nxt = '0;
    return nxt;
  endfunction

  logic at_limit;
  logic clear;

  assign at_limit   = (count_o >= limit_i);
  assign overflow_o = at_limit;

`ifdef COUNTER_CLR_EN
  assign clear = clr_i;
`else
  assign clear = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (clear) begin
      count_o <= '0;
    end else begin
      count_o <= next_count(count_o, at_limit);
    end
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: stimulus pushes expected per-cycle count/overflow from a phase-position model,
// a negedge monitor pops and compares.
module tb_counter;
  localparam int W = 11;

  logic         clk_i   = 1'b0;
  logic         rst_ni  = 1'b1;
  logic [W-1:0] limit_i = '0;
  logic [W-1:0] count_o;
  logic         overflow_o;
`ifdef COUNTER_CLR_EN
  logic         clr_i   = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  counter #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
`ifdef COUNTER_CLR_EN
    .clr_i      (clr_i),
`endif
    .limit_i    (limit_i),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] cnt;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: the count is the number of cycles elapsed since the current phase began.
  int unsigned t           = 0;
  int unsigned phase_start = 0;

  task automatic step(input int unsigned lim, input bit rst, input bit clr, input string tag);
    exp_t        e;
    int unsigned pos;
    @(posedge clk_i);
    #1;
    limit_i = lim[W-1:0];
    rst_ni  = rst;
`ifdef COUNTER_CLR_EN
    clr_i   = clr;
`endif
    if (!rst) phase_start = t;
    pos   = t - phase_start;
    e.tag = tag;
    e.cnt = pos[W-1:0];
    e.ovf = (pos >= lim);
    sb.push_back(e);
    if (!rst || clr || pos >= lim) phase_start = t + 1;
    t++;
  endtask

  task automatic run_until(input int unsigned lim, input int unsigned target, input string tag);
    int n;
    n = 0;
    while ((t - phase_start) != target && n < 4096) begin
      step(lim, 1'b1, 1'b0, tag);
      n++;
    end
    if ((t - phase_start) != target) begin
      errors++;
      $display("FAIL %s: model position %0d never reached target %0d", tag, t - phase_start, target);
    end
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (count_o !== mon_e.cnt || overflow_o !== mon_e.ovf) begin
        errors++;
        $display("FAIL %s: count_o=%0d overflow_o=%0b, expected count_o=%0d overflow_o=%0b",
                 mon_e.tag, count_o, overflow_o, mon_e.cnt, mon_e.ovf);
      end
    end
  end

  initial begin
    int unsigned lim;
    bit          rst;
    bit          clr;

    #1 rst_ni = 1'b0;

    repeat (4) step(19, 1'b0, 1'b0, "reset_hold");

    run_until(19, 5, "pre_async");
    step(19, 1'b0, 1'b0, "reset_async");
    step(19, 1'b1, 1'b0, "after_async");
    step(19, 1'b0, 1'b0, "reset_again");

    repeat (9) step(2, 1'b1, 1'b0, "period_l2");

    run_until(19, 19, "run_l19");
    step(2, 1'b1, 1'b0, "wrap_switch");
    repeat (6) step(2, 1'b1, 1'b0, "new_phase_l2");

    run_until(19, 10, "run_to_10");
    step(4, 1'b1, 1'b0, "lower_below");
    repeat (6) step(4, 1'b1, 1'b0, "after_lower");

    repeat (6) step(0, 1'b1, 1'b0, "limit_zero");

    repeat (2052) step(2047, 1'b1, 1'b0, "limit_max");

`ifdef COUNTER_CLR_EN
    run_until(19, 7, "run_to_7");
    step(19, 1'b1, 1'b1, "clr_pulse");
    repeat (22) step(19, 1'b1, 1'b0, "after_clr");
`endif

    lim = 7;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7, 0) == 0) lim = $urandom_range(31, 0);
      rst = ($urandom_range(63, 0) != 0);
      clr = 1'b0;
`ifdef COUNTER_CLR_EN
      clr = ($urandom_range(31, 0) == 0);
`endif
      step(lim, rst, clr, "random");
    end
    step(lim, 1'b1, 1'b0, "random_tail");

    @(negedge clk_i);
    @(negedge clk_i);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
